// File: rtl/muldiv_ctrl_pkg.sv
// muldiv_ctrl_pkg: shared constants for the HI/LO multiply/divide unit.
// Holds es_op bit indices, FSM state encodings and a magnitude helper.
package muldiv_ctrl_pkg;

    localparam int MD_OP_WD = 8;

    // es_op bit positions (alu_op[19:12]); signed divide is MD_DIVS
    // so that its name does not collide with the MD_DIV state.
    localparam int MD_MULT  = 0;
    localparam int MD_MULTU = 1;
    localparam int MD_DIVS  = 2;
    localparam int MD_DIVU  = 3;
    localparam int MD_MFHI  = 4;
    localparam int MD_MFLO  = 5;
    localparam int MD_MTHI  = 6;
    localparam int MD_MTLO  = 7;

    localparam logic [1:0] MD_IDLE = 2'd0;
    localparam logic [1:0] MD_MUL  = 2'd1;
    localparam logic [1:0] MD_DIV  = 2'd2;
    localparam logic [1:0] MD_FIX  = 2'd3;

    function automatic logic [31:0] md_abs(input logic [31:0] v,
                                           input logic        sgn);
        return (sgn & v[31]) ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// muldiv_ctrl_if: EXE-stage <-> HI/LO unit bundle.
// master = EXE stage (drives es_*/flush), slave = muldiv_ctrl.
interface muldiv_ctrl_if;
    import muldiv_ctrl_pkg::*;

    logic                es_valid;
    logic [MD_OP_WD-1:0] es_op;
    logic [31:0]         es_src1;
    logic [31:0]         es_src2;
    logic                es_cancel;
    logic                es_advance;
    logic                flush;
    logic                md_busy;
    logic [31:0]         md_rdata;
    logic [31:0]         hi_q;
    logic [31:0]         lo_q;

    modport master (
        output es_valid, es_op, es_src1, es_src2,
        output es_cancel, es_advance, flush,
        input  md_busy, md_rdata, hi_q, lo_q
    );

    modport slave (
        input  es_valid, es_op, es_src1, es_src2,
        input  es_cancel, es_advance, flush,
        output md_busy, md_rdata, hi_q, lo_q
    );

endinterface

// File: rtl/muldiv_ctrl_div_iter.sv
// muldiv_ctrl_div_iter: restoring radix-2 divider datapath, one bit/cycle.
// Ports: clk, reset, load_i/early_i/step_i, dvd_i/dvs_i magnitudes, quot_o, rem_o.
module muldiv_ctrl_div_iter (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_i,
    input  logic        early_i,
    input  logic        step_i,
    input  logic [31:0] dvd_i,
    input  logic [31:0] dvs_i,
    output logic [31:0] quot_o,
    output logic [31:0] rem_o
);

    logic [31:0] rem_q, rem_d;
    logic [31:0] quot_q, quot_d;
    logic [31:0] dvs_q, dvs_d;
    logic [32:0] part;
    logic        ge;

    // Dividend bits shift out of quot_q into the partial remainder.
    assign part = {rem_q, quot_q[31]};
    assign ge   = part >= {1'b0, dvs_q};

    always_comb begin
        rem_d  = rem_q;
        quot_d = quot_q;
        dvs_d  = dvs_q;
        if (load_i) begin
            dvs_d = dvs_i;
            // Early-out loads the finished answer: q=0, r=a.
            rem_d  = early_i ? dvd_i : 32'd0;
            quot_d = early_i ? 32'd0 : dvd_i;
        end else if (step_i) begin
            // When ge the difference is below the divisor, so 32 bits hold it.
            rem_d  = ge ? (part[31:0] - dvs_q) : part[31:0];
            quot_d = {quot_q[30:0], ge};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rem_q  <= '0;
            quot_q <= '0;
            dvs_q  <= '0;
        end else begin
            rem_q  <= rem_d;
            quot_q <= quot_d;
            dvs_q  <= dvs_d;
        end
    end

    assign quot_o = quot_q;
    assign rem_o  = rem_q;

endmodule

// File: rtl/muldiv_ctrl.sv
// muldiv_ctrl: HI/LO mult/div sequencer for EXE; owns HI/LO, stalls while busy.
// Ports: clk, reset (sync, active-high), bus (muldiv_ctrl_if.slave). Option: MULDIV_EARLY_OUT_EN.
module muldiv_ctrl #(
    parameter int MUL_LAT  = 1,
    parameter int DIV_ITER = 32
) (
    input logic           clk,
    input logic           reset,
    muldiv_ctrl_if.slave  bus
);
    import muldiv_ctrl_pkg::*;

    localparam int CW = 6;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic [31:0]   a_q, a_d, b_q, b_d;
    logic          sgn_q, sgn_d;

    logic        is_mul, is_div, op_sgn, start, abort, early;
    logic        sa, sb;
    logic [31:0] dvd_mag, dvs_mag, quot, rem, q_fix, r_fix;
    logic [63:0] ax, bx, prod;

    assign is_mul = bus.es_op[MD_MULT] | bus.es_op[MD_MULTU];
    assign is_div = bus.es_op[MD_DIVS] | bus.es_op[MD_DIVU];
    assign op_sgn = bus.es_op[MD_MULT] | bus.es_op[MD_DIVS];

    // done_q keeps a finished op stalled downstream from re-issuing.
    assign start = bus.es_valid & (is_mul | is_div) & (state_q == MD_IDLE)
                 & ~done_q & ~bus.es_cancel & ~bus.flush;
    assign abort = (bus.es_cancel | bus.flush) & (state_q != MD_IDLE);

    assign dvd_mag = md_abs(bus.es_src1, op_sgn);
    assign dvs_mag = md_abs(bus.es_src2, op_sgn);

`ifdef MULDIV_EARLY_OUT_EN
    assign early = (dvs_mag != 32'd0) && (dvd_mag < dvs_mag);
`else
    assign early = 1'b0;
`endif

    muldiv_ctrl_div_iter u_div (
        .clk     (clk),
        .reset   (reset),
        .load_i  (start & is_div),
        .early_i (early),
        .step_i  ((state_q == MD_DIV) & ~abort),
        .dvd_i   (dvd_mag),
        .dvs_i   (dvs_mag),
        .quot_o  (quot),
        .rem_o   (rem)
    );

    // 33-bit extension; the low 64 bits of the product are sign-correct.
    assign ax   = {{32{sgn_q & a_q[31]}}, a_q};
    assign bx   = {{32{sgn_q & b_q[31]}}, b_q};
    assign prod = ax * bx;

    assign sa = sgn_q & a_q[31];
    assign sb = sgn_q & b_q[31];

    always_comb begin
        q_fix = (sa ^ sb) ? (~quot + 32'd1) : quot;
        r_fix = sa ? (~rem + 32'd1) : rem;
        // Signed divide by zero returns the documented fixed quotient.
        if (sgn_q && (b_q == 32'd0)) q_fix = sa ? 32'hFFFF_FFFF : 32'd1;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        done_d  = done_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        a_d     = a_q;
        b_d     = b_q;
        sgn_d   = sgn_q;
        case (state_q)
            MD_IDLE: begin
                if (start) begin
                    a_d   = bus.es_src1;
                    b_d   = bus.es_src2;
                    sgn_d = op_sgn;
                    if (is_mul) begin
                        state_d = MD_MUL;
                        cnt_d   = CW'(MUL_LAT - 1);
                    end else if (early) begin
                        state_d = MD_FIX;
                    end else begin
                        state_d = MD_DIV;
                        cnt_d   = CW'(DIV_ITER - 1);
                    end
                end
            end
            MD_MUL: begin
                if (abort) begin
                    state_d = MD_IDLE;
                end else if (cnt_q == '0) begin
                    hi_d    = prod[63:32];
                    lo_d    = prod[31:0];
                    state_d = MD_IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            MD_DIV: begin
                if (abort)             state_d = MD_IDLE;
                else if (cnt_q == '0)  state_d = MD_FIX;
                else                   cnt_d   = cnt_q - CW'(1);
            end
            default: begin
                if (!abort) begin
                    lo_d   = q_fix;
                    hi_d   = r_fix;
                    done_d = 1'b1;
                end
                state_d = MD_IDLE;
            end
        endcase
        if (bus.es_valid & ~bus.es_cancel & ~bus.flush & bus.es_advance) begin
            if (bus.es_op[MD_MTHI]) hi_d = bus.es_src1;
            if (bus.es_op[MD_MTLO]) lo_d = bus.es_src1;
        end
        if (abort | bus.es_advance | bus.flush) done_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= MD_IDLE;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            hi_q    <= '0;
            lo_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            sgn_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sgn_q   <= sgn_d;
        end
    end

    // Last MUL cycle and FIX are not busy: write and advance share an edge.
    assign bus.md_busy = start
                       | ((((state_q == MD_MUL) & (cnt_q != '0))
                          | (state_q == MD_DIV)) & ~abort);

    always_comb begin
        bus.md_rdata = '0;
        unique case (1'b1)
            bus.es_op[MD_MFHI]: bus.md_rdata = hi_q;
            bus.es_op[MD_MFLO]: bus.md_rdata = lo_q;
            default:            bus.md_rdata = '0;
        endcase
    end

    assign bus.hi_q = hi_q;
    assign bus.lo_q = lo_q;

endmodule

// File: doc/muldiv_ctrl.md
Name: muldiv_ctrl

Overview:
- Sequences the HI/LO multiply/divide resource for the EXE stage of the 5-stage MIPS pipeline.
- Accepts mult/multu/div/divu/mfhi/mflo/mthi/mtlo from decoded alu_op[19:12] and runs a fixed-latency multiply and a 32-iteration radix-2 divider.
- Raises a stall while busy, owns the HI/LO registers and serves mfhi/mflo reads.
- Aborts in-flight work on exception flush or cancel, leaving HI/LO untouched.

Parameters:
- MUL_LAT, 1, cycles spent in MUL state after the issue cycle (1..4).
- DIV_ITER, 32, divider iteration count (fixed 32 for 32-bit operands).

Ports:
- clk  in  1  clock
- reset  in  1  reset; synchronous, active-high
- es_valid  in  1  EXE holds a valid instruction
- es_op  in  8  {mtlo,mthi,mflo,mfhi,divu,div,multu,mult} = alu_op[19:12]
- es_src1  in  32  rs value
- es_src2  in  32  rt value
- es_cancel  in  1  EXE instruction must not commit (EXE exception or later-stage exception)
- es_advance  in  1  EXE instruction leaves EXE this cycle
- flush  in  1  CP0 pipeline flush
- md_busy  out  1  stall EXE (ready_go low)
- md_rdata  out  32  HI (mfhi) or LO (mflo), else 0
- hi_q  out  32  current HI
- lo_q  out  32  current LO

Behaviour:
- Reset: state=IDLE, HI=LO=0, done_r=0, cnt=0, md_busy=0, md_rdata=0.
- States: IDLE, MUL, DIV, FIX.
- start = es_valid & (mult|multu|div|divu) & state==IDLE & ~done_r & ~es_cancel & ~flush.
- Issue cycle (IDLE):
  - Operands latched; signedness latched.
  - mult/multu -> MUL with cnt=MUL_LAT-1.
  - div/divu -> DIV with cnt=DIV_ITER-1; magnitudes latched for div.
- MUL:
  - 33x33 signed product computed (zero-extend for multu).
  - When cnt==0: HI=prod[63:32], LO=prod[31:0]; go to IDLE; done_r<=1.
  - Otherwise cnt decrements.
- DIV: one restoring iteration per cycle; after cnt==0, go to FIX.
- FIX:
  - Signed div: quotient negated if sign(a)^sign(b); remainder negated if sign(a).
  - LO=quotient, HI=remainder; go to IDLE; done_r<=1.
- md_busy = start | (state==MUL & cnt!=0) | state==DIV.
  - Deasserted in the final MUL cycle and in FIX, so HI/LO write and EXE advance share one edge.
- Latency from EXE entry:
  - mult: 1+MUL_LAT cycles (2 at default).
  - div: 1+32+1 = 34 cycles.
- done_r: cleared on es_advance or flush. Blocks re-issue of a finished op held in EXE by a downstream stall.
- mthi/mtlo: HI/LO written at the edge when es_valid & ~es_cancel & ~flush & es_advance. No stall.
- mfhi/mflo: md_rdata combinational from HI/LO.
  - An in-flight op cannot coexist with a younger op in EXE, so no bypass is needed.
- flush or es_cancel while state!=IDLE: go to IDLE next edge; no HI/LO write; done_r=0; md_busy drops that cycle.
- Flush and final cycle coincide: flush wins; no write.
- Divide by zero, defined by the algorithm:
  - divu: LO=0xFFFFFFFF, HI=a.
  - div: LO = a<0 ? 0xFFFFFFFF : 0x00000001; HI=a.
- 0x80000000 div 0xFFFFFFFF: LO=0x80000000, HI=0.
- Reset mid-operation: immediate return to reset values.

Optional Feature:
- MULDIV_EARLY_OUT_EN.
- Defined: at issue, if |a|<|b| with b!=0, DIV is skipped (IDLE -> FIX directly) with quotient 0 and remainder a. Total div latency is 2 cycles.
- Undefined: every div takes 34 cycles. Results are identical either way.

Decomposition:
- Shared package/header:
  - es_op bit indices (MD_MULT..MD_MTLO).
  - State encodings (MD_IDLE, MD_MUL, MD_DIV, MD_FIX).
  - MD_OP_WD=8.
- Sub-module div_iter holds the restoring-divide datapath: remainder/quotient shift registers and one subtract per cycle.
- muldiv_ctrl keeps the FSM, counters, HI/LO and the multiplier.

Test Plan:
- mult 0xFFFFFFFE x 0x00000003, es_advance on release -> busy 1 cycle; HI=0xFFFFFFFF, LO=0xFFFFFFFA; mflo next returns 0xFFFFFFFA.
- divu 100/7 -> busy 33 cycles then release; LO=14, HI=2. div -100/7 -> LO=0xFFFFFFF2, HI=0xFFFFFFFE.
- div 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0. divu 5/0 -> LO=0xFFFFFFFF, HI=5.
- flush at DIV cycle 10 of divu 100/7 with prior HI=0x11, LO=0x22 -> IDLE next cycle, busy 0; HI/LO unchanged.
- Completed mult held with es_advance=0 for 3 cycles -> no re-issue, busy 0, HI/LO written once. Then mthi 0xABCD with es_advance=1 -> HI=0xABCD.
- With MULDIV_EARLY_OUT_EN: divu 3/9 -> busy 1 cycle, LO=0, HI=3. Without it: same result after 34 cycles.
